// File: rtl/axi_lite_arbiter_nx1.sv
// N-to-1 AXI-Lite arbiter: independent round-robin write and read paths, one outstanding
// transaction per direction, grant held from arbitration until the response handshake.
module axi_lite_arbiter_nx1 #(
  parameter int N          = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N*ADDR_WIDTH-1:0]    s_aw_addr,
  input  logic [N-1:0]               s_aw_valid,
  output logic [N-1:0]               s_aw_ready,
  input  logic [N*DATA_WIDTH-1:0]    s_w_data,
  input  logic [N*DATA_WIDTH/8-1:0]  s_w_strb,
  input  logic [N-1:0]               s_w_valid,
  output logic [N-1:0]               s_w_ready,
  output logic [2*N-1:0]             s_b_resp,
  output logic [N-1:0]               s_b_valid,
  input  logic [N-1:0]               s_b_ready,
  input  logic [N*ADDR_WIDTH-1:0]    s_ar_addr,
  input  logic [N-1:0]               s_ar_valid,
  output logic [N-1:0]               s_ar_ready,
  output logic [N*DATA_WIDTH-1:0]    s_r_data,
  output logic [2*N-1:0]             s_r_resp,
  output logic [N-1:0]               s_r_valid,
  input  logic [N-1:0]               s_r_ready,
  output logic [ADDR_WIDTH-1:0]      m_aw_addr,
  output logic                       m_aw_valid,
  input  logic                       m_aw_ready,
  output logic [DATA_WIDTH-1:0]      m_w_data,
  output logic [DATA_WIDTH/8-1:0]    m_w_strb,
  output logic                       m_w_valid,
  input  logic                       m_w_ready,
  input  logic [1:0]                 m_b_resp,
  input  logic                       m_b_valid,
  output logic                       m_b_ready,
  output logic [ADDR_WIDTH-1:0]      m_ar_addr,
  output logic                       m_ar_valid,
  input  logic                       m_ar_ready,
  input  logic [DATA_WIDTH-1:0]      m_r_data,
  input  logic [1:0]                 m_r_resp,
  input  logic                       m_r_valid,
  output logic                       m_r_ready,
  output logic                       wr_busy,
  output logic                       rd_busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {WR_IDLE, WR_ADDR, WR_RESP} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_RESP} rd_state_t;

  wr_state_t      wr_state, wr_state_nxt;
  rd_state_t      rd_state, rd_state_nxt;
  logic [IW-1:0]  wr_gnt, wr_gnt_nxt, wr_ptr, wr_ptr_nxt;
  logic [IW-1:0]  rd_gnt, rd_gnt_nxt, rd_ptr, rd_ptr_nxt;
  logic           aw_done, aw_done_nxt, w_done, w_done_nxt;

  // First requester at or after ptr, wrapping cyclically.
  function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] req, input logic [IW-1:0] ptr);
    logic [IW-1:0] pick;
    int            idx;
    pick = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx]) pick = IW'(idx);
    end
    return pick;
  endfunction

  function automatic logic [IW-1:0] ptr_after(input logic [IW-1:0] g);
    return (g == IW'(N - 1)) ? '0 : g + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state <= WR_IDLE;
      rd_state <= RD_IDLE;
      wr_gnt   <= '0;
      rd_gnt   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      wr_state <= wr_state_nxt;
      rd_state <= rd_state_nxt;
      wr_gnt   <= wr_gnt_nxt;
      rd_gnt   <= rd_gnt_nxt;
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      aw_done  <= aw_done_nxt;
      w_done   <= w_done_nxt;
    end
  end

  always_comb begin
    wr_state_nxt = wr_state;
    wr_gnt_nxt   = wr_gnt;
    wr_ptr_nxt   = wr_ptr;
    aw_done_nxt  = aw_done;
    w_done_nxt   = w_done;
    m_aw_addr    = s_aw_addr[int'(wr_gnt)*ADDR_WIDTH +: ADDR_WIDTH];
    m_w_data     = s_w_data[int'(wr_gnt)*DATA_WIDTH +: DATA_WIDTH];
    m_w_strb     = s_w_strb[int'(wr_gnt)*SW +: SW];
    m_aw_valid   = 1'b0;
    m_w_valid    = 1'b0;
    m_b_ready    = 1'b0;
    s_aw_ready   = '0;
    s_w_ready    = '0;
    s_b_valid    = '0;
    s_b_resp     = '0;
    case (wr_state)
      WR_IDLE: begin
        if (|s_aw_valid) begin
          wr_gnt_nxt   = rr_pick(s_aw_valid, wr_ptr);
          aw_done_nxt  = 1'b0;
          w_done_nxt   = 1'b0;
          wr_state_nxt = WR_ADDR;
        end
      end
      WR_ADDR: begin
        // AW and W complete independently; each side is masked once it has handshaken.
        m_aw_valid         = s_aw_valid[wr_gnt] & ~aw_done;
        m_w_valid          = s_w_valid[wr_gnt] & ~w_done;
        s_aw_ready[wr_gnt] = m_aw_ready & ~aw_done;
        s_w_ready[wr_gnt]  = m_w_ready & ~w_done;
        if (m_aw_valid && m_aw_ready) aw_done_nxt = 1'b1;
        if (m_w_valid && m_w_ready)   w_done_nxt  = 1'b1;
        if (aw_done_nxt && w_done_nxt) wr_state_nxt = WR_RESP;
      end
      WR_RESP: begin
        m_b_ready                       = s_b_ready[wr_gnt];
        s_b_valid[wr_gnt]               = m_b_valid;
        s_b_resp[2*int'(wr_gnt) +: 2]   = m_b_resp;
        if (m_b_valid && s_b_ready[wr_gnt]) begin
          wr_ptr_nxt   = ptr_after(wr_gnt);
          wr_state_nxt = WR_IDLE;
        end
      end
      default: wr_state_nxt = WR_IDLE;
    endcase
  end

  always_comb begin
    rd_state_nxt = rd_state;
    rd_gnt_nxt   = rd_gnt;
    rd_ptr_nxt   = rd_ptr;
    m_ar_addr    = s_ar_addr[int'(rd_gnt)*ADDR_WIDTH +: ADDR_WIDTH];
    m_ar_valid   = 1'b0;
    m_r_ready    = 1'b0;
    s_ar_ready   = '0;
    s_r_valid    = '0;
    s_r_data     = '0;
    s_r_resp     = '0;
    case (rd_state)
      RD_IDLE: begin
        if (|s_ar_valid) begin
          rd_gnt_nxt   = rr_pick(s_ar_valid, rd_ptr);
          rd_state_nxt = RD_ADDR;
        end
      end
      RD_ADDR: begin
        m_ar_valid         = s_ar_valid[rd_gnt];
        s_ar_ready[rd_gnt] = m_ar_ready;
        if (s_ar_valid[rd_gnt] && m_ar_ready) rd_state_nxt = RD_RESP;
      end
      RD_RESP: begin
        m_r_ready                                       = s_r_ready[rd_gnt];
        s_r_valid[rd_gnt]                               = m_r_valid;
        s_r_data[int'(rd_gnt)*DATA_WIDTH +: DATA_WIDTH] = m_r_data;
        s_r_resp[2*int'(rd_gnt) +: 2]                   = m_r_resp;
        if (m_r_valid && s_r_ready[rd_gnt]) begin
          rd_ptr_nxt   = ptr_after(rd_gnt);
          rd_state_nxt = RD_IDLE;
        end
      end
      default: rd_state_nxt = RD_IDLE;
    endcase
  end

  assign wr_busy = (wr_state != WR_IDLE);
  assign rd_busy = (rd_state != RD_IDLE);

endmodule

// File: tb/tb_axi_lite_arbiter_nx1.sv
// Directed bench for the 2-master AXI-Lite arbiter; inputs change and outputs are sampled mid-low-phase.
module tb_axi_lite_arbiter_nx1;
  localparam int N = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  logic [N*AW-1:0]   s_aw_addr;
  logic [N-1:0]      s_aw_valid, s_aw_ready;
  logic [N*DW-1:0]   s_w_data;
  logic [N*DW/8-1:0] s_w_strb;
  logic [N-1:0]      s_w_valid, s_w_ready;
  logic [2*N-1:0]    s_b_resp;
  logic [N-1:0]      s_b_valid, s_b_ready;
  logic [N*AW-1:0]   s_ar_addr;
  logic [N-1:0]      s_ar_valid, s_ar_ready;
  logic [N*DW-1:0]   s_r_data;
  logic [2*N-1:0]    s_r_resp;
  logic [N-1:0]      s_r_valid, s_r_ready;
  logic [AW-1:0]     m_aw_addr, m_ar_addr;
  logic              m_aw_valid, m_aw_ready, m_w_valid, m_w_ready;
  logic [DW-1:0]     m_w_data, m_r_data;
  logic [DW/8-1:0]   m_w_strb;
  logic [1:0]        m_b_resp, m_r_resp;
  logic              m_b_valid, m_b_ready, m_ar_valid, m_ar_ready, m_r_valid, m_r_ready;
  logic              wr_busy, rd_busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axi_lite_arbiter_nx1 #(.N(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .s_aw_addr(s_aw_addr), .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready),
    .s_w_data(s_w_data), .s_w_strb(s_w_strb), .s_w_valid(s_w_valid), .s_w_ready(s_w_ready),
    .s_b_resp(s_b_resp), .s_b_valid(s_b_valid), .s_b_ready(s_b_ready),
    .s_ar_addr(s_ar_addr), .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready),
    .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_valid(s_r_valid), .s_r_ready(s_r_ready),
    .m_aw_addr(m_aw_addr), .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready),
    .m_w_data(m_w_data), .m_w_strb(m_w_strb), .m_w_valid(m_w_valid), .m_w_ready(m_w_ready),
    .m_b_resp(m_b_resp), .m_b_valid(m_b_valid), .m_b_ready(m_b_ready),
    .m_ar_addr(m_ar_addr), .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
    .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_valid(m_r_valid), .m_r_ready(m_r_ready),
    .wr_busy(wr_busy), .rd_busy(rd_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  logic [DW-1:0] rd_vals [4];

  initial begin
    rst = 1'b1;
    s_aw_addr = '0; s_aw_valid = '0; s_w_data = '0; s_w_strb = '0; s_w_valid = '0;
    s_b_ready = '0; s_ar_addr = '0; s_ar_valid = '0; s_r_ready = '0;
    m_aw_ready = 0; m_w_ready = 0; m_b_resp = '0; m_b_valid = 0;
    m_ar_ready = 0; m_r_data = '0; m_r_resp = '0; m_r_valid = 0;
    rd_vals[0] = 32'hA0; rd_vals[1] = 32'hB1; rd_vals[2] = 32'hA2; rd_vals[3] = 32'hB3;

    // Reset state
    step(); step(); #1;
    chk("rst_m_aw_valid", 64'(m_aw_valid), 64'd0);
    chk("rst_m_ar_valid", 64'(m_ar_valid), 64'd0);
    chk("rst_s_aw_ready", 64'(s_aw_ready), 64'd0);
    chk("rst_s_b_valid",  64'(s_b_valid),  64'd0);
    chk("rst_s_r_valid",  64'(s_r_valid),  64'd0);
    chk("rst_busy",       64'({wr_busy, rd_busy}), 64'd0);
    chk("rst_m_b_ready",  64'(m_b_ready), 64'd0);
    rst = 1'b0;

    // Single write from master 1, AW and W together
    step();
    s_aw_addr[AW +: AW] = 32'h10; s_w_data[DW +: DW] = 32'hDEADBEEF; s_w_strb[4 +: 4] = 4'hF;
    s_aw_valid = 2'b10; s_w_valid = 2'b10; m_aw_ready = 1; m_w_ready = 1; #1;
    chk("w1_idle_aw_valid", 64'(m_aw_valid), 64'd0);
    step(); #1;
    chk("w1_aw_valid", 64'(m_aw_valid), 64'd1);
    chk("w1_aw_addr",  64'(m_aw_addr),  64'h10);
    chk("w1_w_data",   64'(m_w_data),   64'hDEADBEEF);
    chk("w1_w_strb",   64'(m_w_strb),   64'hF);
    chk("w1_aw_ready", 64'(s_aw_ready), 64'b10);
    chk("w1_w_ready",  64'(s_w_ready),  64'b10);
    chk("w1_wr_busy",  64'(wr_busy),    64'd1);
    step();
    s_aw_valid = '0; s_w_valid = '0; m_b_valid = 1; m_b_resp = 2'b00; s_b_ready = 2'b10; #1;
    chk("w1_b_valid", 64'(s_b_valid), 64'b10);
    chk("w1_b_resp",  64'(s_b_resp),  64'd0);
    chk("w1_b_ready", 64'(m_b_ready), 64'd1);
    chk("w1_resp_aw_valid", 64'(m_aw_valid), 64'd0);
    step();
    m_b_valid = 0; s_b_ready = '0; #1;
    chk("w1_done_busy",    64'(wr_busy),   64'd0);
    chk("w1_done_b_valid", 64'(s_b_valid), 64'd0);

    // Round-robin reads: both masters request four times back to back
    s_ar_addr[0 +: AW] = 32'h100; s_ar_addr[AW +: AW] = 32'h200; m_ar_ready = 1; s_r_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      step();
      s_ar_valid = 2'b11; m_r_valid = 0; #1;
      chk("rr_idle", 64'(rd_busy), 64'd0);
      step(); #1;
      chk("rr_ar_ready", 64'(s_ar_ready), 64'(2'b01 << (i % 2)));
      chk("rr_ar_addr",  64'(m_ar_addr),  (i % 2 == 0) ? 64'h100 : 64'h200);
      step();
      m_r_valid = 1; m_r_data = rd_vals[i]; #1;
      chk("rr_r_valid", 64'(s_r_valid), 64'(2'b01 << (i % 2)));
      chk("rr_r_data",  64'(s_r_data),  64'(rd_vals[i]) << (32 * (i % 2)));
    end
    step();
    m_r_valid = 0; s_ar_valid = '0; s_r_ready = '0; m_ar_ready = 0;

    // Split AW/W on master 0, delayed B with B ready held low
    s_aw_addr[0 +: AW] = 32'h20; s_w_data[0 +: DW] = 32'h12345678; s_w_strb[0 +: 4] = 4'h3;
    s_aw_valid = 2'b01; s_w_valid = 2'b01; m_aw_ready = 1; m_w_ready = 0;
    step(); #1;
    chk("sp_aw_ready", 64'(s_aw_ready), 64'b01);
    chk("sp_w_held",   64'(s_w_ready),  64'b00);
    step();
    s_aw_valid = '0; #1;
    chk("sp_aw_done_mask", 64'(m_aw_valid), 64'd0);
    chk("sp_w_valid",      64'(m_w_valid),  64'd1);
    step(); step();
    m_w_ready = 1; #1;
    chk("sp_w_ready", 64'(s_w_ready), 64'b01);
    chk("sp_w_data",  64'(m_w_data),  64'h12345678);
    step();
    s_w_valid = '0; m_w_ready = 0; #1;
    chk("sp_resp_busy",    64'(wr_busy),    64'd1);
    chk("sp_no_dup_aw_w",  64'({m_aw_valid, m_w_valid}), 64'd0);
    step(); step(); step(); step(); #1;
    chk("sp_no_b_yet", 64'(s_b_valid), 64'd0);
    step();
    m_b_valid = 1; m_b_resp = 2'b10; s_b_ready = '0; #1;
    chk("sp_b_valid", 64'(s_b_valid), 64'b01);
    chk("sp_b_resp",  64'(s_b_resp),  64'b0010);
    chk("sp_b_ready_low1", 64'(m_b_ready), 64'd0);
    step(); #1;
    chk("sp_b_ready_low2", 64'(m_b_ready), 64'd0);
    chk("sp_b_still",      64'(s_b_valid), 64'b01);
    step();
    s_b_ready = 2'b01; #1;
    chk("sp_b_ready", 64'(m_b_ready), 64'd1);
    step();
    m_b_valid = 0; s_b_ready = '0; #1;
    chk("sp_single_b", 64'(s_b_valid), 64'd0);
    chk("sp_idle",     64'(wr_busy),   64'd0);

    // Concurrent paths: master 0 writes while master 1 reads
    s_aw_addr[0 +: AW] = 32'h30; s_ar_addr[AW +: AW] = 32'h340;
    s_aw_valid = 2'b01; s_w_valid = 2'b01; s_ar_valid = 2'b10;
    step(); #1;
    chk("cc_both_busy", 64'({wr_busy, rd_busy}), 64'b11);
    chk("cc_ar_addr",   64'(m_ar_addr), 64'h340);
    chk("cc_aw_addr",   64'(m_aw_addr), 64'h30);
    chk("cc_ar_wait",   64'(s_ar_ready), 64'd0);
    m_aw_ready = 1; m_w_ready = 1; m_ar_ready = 1; #1;
    chk("cc_aw_ready", 64'(s_aw_ready), 64'b01);
    chk("cc_ar_ready", 64'(s_ar_ready), 64'b10);
    step();
    s_aw_valid = '0; s_w_valid = '0; s_ar_valid = '0; m_aw_ready = 0; m_w_ready = 0; m_ar_ready = 0;
    m_b_valid = 1; m_b_resp = 2'b01; s_b_ready = 2'b01;
    m_r_valid = 1; m_r_data = 32'hCAFE; m_r_resp = 2'b11; s_r_ready = 2'b10; #1;
    chk("cc_b_valid", 64'(s_b_valid), 64'b01);
    chk("cc_b_resp",  64'(s_b_resp),  64'b0001);
    chk("cc_r_valid", 64'(s_r_valid), 64'b10);
    chk("cc_r_data",  64'(s_r_data),  64'h0000CAFE_00000000);
    chk("cc_r_resp",  64'(s_r_resp),  64'b1100);
    chk("cc_r_ready", 64'(m_r_ready), 64'd1);
    step();
    m_b_valid = 0; m_r_valid = 0; s_b_ready = '0; s_r_ready = '0; m_r_resp = '0; #1;
    chk("cc_both_idle", 64'({wr_busy, rd_busy}), 64'b00);

    // Fairness: master 0 reads continuously, master 1 joins once
    s_ar_valid = 2'b01; m_ar_ready = 1; s_r_ready = 2'b11;
    step();
    s_ar_valid = 2'b11; #1;
    chk("fa_first_m0", 64'(s_ar_ready), 64'b01);
    step();
    m_r_valid = 1; m_r_data = 32'h55; #1;
    chk("fa_r_m0", 64'(s_r_valid), 64'b01);
    step();
    m_r_valid = 0;
    step(); #1;
    chk("fa_next_m1",   64'(s_ar_ready), 64'b10);
    chk("fa_m1_addr",   64'(m_ar_addr),  64'h340);
    step();
    s_ar_valid = 2'b01; m_r_valid = 1; m_r_data = 32'h66; #1;
    chk("fa_r_m1", 64'(s_r_valid), 64'b10);
    step();
    m_r_valid = 0; s_ar_valid = '0; s_r_ready = '0; m_ar_ready = 0;

    // Reset in WR_RESP; wr_ptr was 1, so after reset master 0 must win first
    s_aw_valid = 2'b01; s_w_valid = 2'b01; m_aw_ready = 1; m_w_ready = 1;
    step(); step();
    s_aw_valid = '0; s_w_valid = '0; m_b_valid = 1; m_b_resp = 2'b00; s_b_ready = '0; #1;
    chk("rs_in_resp", 64'(s_b_valid), 64'b01);
    rst = 1'b1;
    step();
    rst = 1'b0; #1;
    chk("rs_b_valid", 64'(s_b_valid), 64'd0);
    chk("rs_outputs", 64'({m_aw_valid, m_w_valid, m_b_ready, m_ar_valid, m_r_ready}), 64'd0);
    chk("rs_busy",    64'({wr_busy, rd_busy}), 64'd0);
    m_b_valid = 0;
    s_aw_addr[0 +: AW] = 32'h40; s_aw_addr[AW +: AW] = 32'h44;
    s_aw_valid = 2'b11; s_w_valid = 2'b11; s_b_ready = 2'b11;
    for (int g = 0; g < 2; g++) begin
      step(); #1;
      chk("rs_gnt", 64'(s_aw_ready), 64'(2'b01 << g));
      chk("rs_addr", 64'(m_aw_addr), (g == 0) ? 64'h40 : 64'h44);
      step();
      s_aw_valid[g] = 1'b0; s_w_valid[g] = 1'b0; m_b_valid = 1; #1;
      chk("rs_b", 64'(s_b_valid), 64'(2'b01 << g));
      step();
      m_b_valid = 0;
    end
    #1;
    chk("rs_end_idle", 64'(wr_busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/axi_lite_arbiter_nx1.md
Name: axi_lite_arbiter_nx1

Overview:
- N AXI-Lite masters share one AXI-Lite slave port.
- Complements the 1xM address-decoding bridge; together they form N×M fabrics.
- Independent write and read arbiters, each round-robin, one outstanding transaction per direction.
- Grant is held from arbitration until the response handshake completes.

Parameters:
N, 2, number of upstream masters (≥2)
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width (multiple of 8)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_aw_addr  in  N*ADDR_WIDTH  per-master AW address, master i at slice i
s_aw_valid  in  N  per-master AW valid
s_aw_ready  out  N  per-master AW ready
s_w_data  in  N*DATA_WIDTH  per-master W data
s_w_strb  in  N*DATA_WIDTH/8  per-master W strobes
s_w_valid  in  N  per-master W valid
s_w_ready  out  N  per-master W ready
s_b_resp  out  2*N  per-master B response
s_b_valid  out  N  per-master B valid
s_b_ready  in  N  per-master B ready
s_ar_addr  in  N*ADDR_WIDTH  per-master AR address
s_ar_valid  in  N  per-master AR valid
s_ar_ready  out  N  per-master AR ready
s_r_data  out  N*DATA_WIDTH  per-master R data
s_r_resp  out  2*N  per-master R response
s_r_valid  out  N  per-master R valid
s_r_ready  in  N  per-master R ready
m_aw_addr/m_aw_valid/m_aw_ready  out/out/in  ADDR_WIDTH/1/1  downstream AW
m_w_data/m_w_strb/m_w_valid/m_w_ready  out/out/out/in  DATA_WIDTH/DATA_WIDTH/8/1/1  downstream W
m_b_resp/m_b_valid/m_b_ready  in/in/out  2/1/1  downstream B
m_ar_addr/m_ar_valid/m_ar_ready  out/out/in  ADDR_WIDTH/1/1  downstream AR
m_r_data/m_r_resp/m_r_valid/m_r_ready  in/in/in/out  DATA_WIDTH/2/1/1  downstream R
wr_busy, rd_busy  out  1 each  path not in IDLE (debug)

Behaviour:
Write FSM states:
- WR_IDLE: request vector = s_aw_valid. If any bit is set, grant the first set index at or after wr_ptr, cyclic. Latch wr_gnt, clear aw_done/w_done, go to WR_ADDR next cycle. Arbitration latency is one cycle.
- WR_ADDR: forward the granted master's AW and W to m_*.
  - m_aw_valid = s_aw_valid[g] & !aw_done; m_w_valid = s_w_valid[g] & !w_done.
  - Ready is returned only to master g; all other s_*_ready = 0.
  - Set aw_done / w_done on the respective handshakes, which may occur in the same or different cycles, in either order.
  - When both are done (including same-cycle completion), go to WR_RESP.
- WR_RESP: m_b_ready = s_b_ready[g]; s_b_valid[g] = m_b_valid; s_b_resp[g] = m_b_resp. Other s_b_valid = 0.
  - On B handshake: wr_ptr <= g+1 mod N, go to WR_IDLE.
  - One idle cycle separates consecutive write grants.

Read FSM states:
- RD_IDLE: same cyclic grant on s_ar_valid using rd_ptr, one-cycle latency. Go to RD_ADDR.
- RD_ADDR: m_ar_* connected to master g. On AR handshake, go to RD_RESP.
- RD_RESP: route m_r_* to master g and s_r_ready[g] to m_r_ready. On R handshake: rd_ptr <= g+1 mod N, go to RD_IDLE.

Datapath and path independence:
- m_*_addr/data/strb are muxed from g in every state; value is don't-care outside ADDR.
- Ungranted s_r_data slices = 0; ungranted s_b_resp/s_r_resp = 0.
- Write and read paths are fully independent and may be granted to the same or different masters simultaneously.
- A master dropping valid while granted in ADDR is a protocol violation; the grant is held regardless, no timeout.
- W arriving before AW from a non-granted master is held off (ready = 0) until that master is granted on AW.

Reset (synchronous, rst high on a clock edge):
- FSMs go to IDLE; wr_ptr = rd_ptr = 0; aw_done = w_done = 0.
- All valid/ready outputs = 0; busy = 0.
- Reset mid-transaction abandons it; no response is generated.

Test Plan:
- Single write: master 1 sends AW 0x10 and W 0xDEADBEEF in the same cycle; slave accepts immediately and returns B OKAY → m_aw_valid 1 cycle after request; s_b_valid[1] = 1 with resp 00; s_b_valid[0] never asserted.
- Round-robin: N=2, both masters hold ar_valid for 4 back-to-back reads → grant order 0,1,0,1; each master's read returns its own m_r_data (0xA0, 0xB1, 0xA2, 0xB3).
- Split AW/W: W handshake 3 cycles after AW; slave B delayed 5 cycles with s_b_ready held low 2 cycles → single B delivered, m_b_ready mirrors s_b_ready[g], no duplicate AW/W.
- Concurrent paths: master 0 writes while master 1 reads, both in flight together → both complete; wr_busy and rd_busy high simultaneously.
- Backpressure fairness: master 0 requests continuously, master 1 requests once → master 1 granted at the next arbitration after the current transaction completes, never starved.
- Reset mid-write: assert rst in WR_RESP → next cycle all valids/readies = 0, wr_ptr = 0; a fresh write from master 1 then completes normally.
